// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the credit-based NoC link.
//   flit_t       : default-width flit payload (data, dest, user, is_tail)
//   credit_width : counter width able to hold 0..n inclusive
package noc_link_pkg;

  localparam int unsigned FLIT_WIDTH_DEF = 128;
  localparam int unsigned USER_WIDTH_DEF = 32;
  localparam int unsigned DEST_WIDTH_DEF = 8;

  typedef struct packed {
    logic [FLIT_WIDTH_DEF-1:0] data;
    logic [DEST_WIDTH_DEF-1:0] dest;
    logic [USER_WIDTH_DEF-1:0] user;
    logic                      is_tail;
  } flit_t;

  function automatic int unsigned credit_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit counter with saturation and sticky overflow flag.
//   consume   : one credit spent this cycle (ignored when count is zero)
//   credit_in : one credit returned this cycle
//   count     : credits currently available (registered)
//   nonzero   : count != 0, decoded from the register
//   full      : count == NUM_CREDITS, decoded from the register
//   overflow  : sticky, set when a return would exceed NUM_CREDITS
module noc_credit_counter
  import noc_link_pkg::*;
#(
  parameter  int unsigned NUM_CREDITS  = 16,
  localparam int unsigned CREDIT_WIDTH = credit_width(NUM_CREDITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    consume,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] count,
  output logic                    nonzero,
  output logic                    full,
  output logic                    overflow
);

  localparam int unsigned SUM_WIDTH = CREDIT_WIDTH + 1;

  logic                 take;
  logic [SUM_WIDTH-1:0] sum;

  // Spend only when a credit exists, so the sum can never wrap below zero.
  assign take = consume & nonzero;
  assign sum  = SUM_WIDTH'(count) - SUM_WIDTH'(take) + SUM_WIDTH'(credit_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= CREDIT_WIDTH'(NUM_CREDITS);
      overflow <= 1'b0;
    end else if (sum > SUM_WIDTH'(NUM_CREDITS)) begin
      count    <= CREDIT_WIDTH'(NUM_CREDITS);
      overflow <= 1'b1;
    end else begin
      count    <= CREDIT_WIDTH'(sum);
    end
  end

  assign nonzero = (count != '0);
  assign full    = (count == CREDIT_WIDTH'(NUM_CREDITS));

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-based link transmitter: accepts flits over valid/ready and emits
// each one as a single-cycle send pulse, never exceeding downstream credits.
//   in_*          : source flit and valid/ready handshake
//   *_out         : registered link flit, meaningful while send_out = 1
//   credit_in     : one-cycle pulse per freed downstream slot
//   credit_count  : available credits
//   idle          : all credits home and nothing being sent
//   credit_overflow : sticky illegal-credit flag
module noc_credit_tx
  import noc_link_pkg::*;
#(
  parameter  int unsigned FLIT_WIDTH   = 128,
  parameter  int unsigned USER_WIDTH   = 32,
  parameter  int unsigned DEST_WIDTH   = 8,
  parameter  int unsigned NUM_CREDITS  = 16,
  localparam int unsigned CREDIT_WIDTH = credit_width(NUM_CREDITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FLIT_WIDTH-1:0]   in_data,
  input  logic [DEST_WIDTH-1:0]   in_dest,
  input  logic [USER_WIDTH-1:0]   in_user,
  input  logic                    in_is_tail,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic [USER_WIDTH-1:0]   user_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    idle,
  output logic                    credit_overflow
);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  is_tail;
  } flit_reg_t;

  flit_reg_t flit_q;
  logic      fire;
  logic      nonzero;
  logic      full;

  assign in_ready = nonzero;
  assign fire     = in_valid & nonzero;

  noc_credit_counter #(
    .NUM_CREDITS (NUM_CREDITS)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .consume   (fire),
    .credit_in (credit_in),
    .count     (credit_count),
    .nonzero   (nonzero),
    .full      (full),
    .overflow  (credit_overflow)
  );

  // Output register: payload captured only on fire, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_q   <= '0;
      send_out <= 1'b0;
    end else begin
      send_out <= fire;
      if (fire) begin
        flit_q.data    <= in_data;
        flit_q.dest    <= in_dest;
        flit_q.user    <= in_user;
        flit_q.is_tail <= in_is_tail;
      end
    end
  end

  assign data_out    = flit_q.data;
  assign dest_out    = flit_q.dest;
  assign user_out    = flit_q.user;
  assign is_tail_out = flit_q.is_tail;

  assign idle = full & ~send_out;

endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed bench for noc_credit_tx with NUM_CREDITS = 4 and a bench-side
// two-stage credit loopback for the ordering scenario.
module tb_noc_credit_tx;

  localparam int unsigned FW = 128;
  localparam int unsigned UW = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic [DW-1:0] in_dest = '0;
  logic [UW-1:0] in_user = '0;
  logic          in_is_tail = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic [UW-1:0] user_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] credit_count;
  logic          idle;
  logic          credit_overflow;

  logic credit_drv = 1'b0;
  logic loop_en = 1'b0;
  logic p1 = 1'b0;
  logic p2 = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Models a 2-stage link plus a receiver echoing every send as a credit.
  always @(posedge clk) begin
    p1 <= send_out;
    p2 <= p1;
  end
  assign credit_in = credit_drv | (loop_en & p2);

  noc_credit_tx #(
    .FLIT_WIDTH  (FW),
    .USER_WIDTH  (UW),
    .DEST_WIDTH  (DW),
    .NUM_CREDITS (NC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_data         (in_data),
    .in_dest         (in_dest),
    .in_user         (in_user),
    .in_is_tail      (in_is_tail),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .data_out        (data_out),
    .dest_out        (dest_out),
    .user_out        (user_out),
    .is_tail_out     (is_tail_out),
    .send_out        (send_out),
    .credit_in       (credit_in),
    .credit_count    (credit_count),
    .idle            (idle),
    .credit_overflow (credit_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] pat(input int k);
    return {FW'(32'hA5A5_0000 + k), 96'h0} | FW'(k * 7 + 1);
  endfunction

  task automatic drive_flit(input int k);
    in_data    = pat(k);
    in_dest    = DW'(k + 8'h10);
    in_user    = UW'(32'hC0DE_0000 + k);
    in_is_tail = (k % 4) == 3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (credit_count !== CW'(NC)) $display("FAIL reset_count got %0d want %0d", credit_count, NC);
    else passes++;
    checks++;
    if (send_out !== 1'b0 || is_tail_out !== 1'b0 || data_out !== '0 || dest_out !== '0 || user_out !== '0)
      $display("FAIL reset_outputs got send=%b tail=%b data=%h dest=%h user=%h want all 0",
               send_out, is_tail_out, data_out, dest_out, user_out);
    else passes++;
    checks++;
    if (credit_overflow !== 1'b0 || in_ready !== 1'b1 || idle !== 1'b1)
      $display("FAIL reset_flags got ovf=%b ready=%b idle=%b want 0 1 1", credit_overflow, in_ready, idle);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Continuous valid with no credits back: exactly NC sends, then stall.
  task automatic test_burst();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_flit(i);
      tick();
      if (i < 4) begin
        checks++;
        if (send_out !== 1'b1 || data_out !== pat(i) || dest_out !== DW'(i + 8'h10) ||
            user_out !== UW'(32'hC0DE_0000 + i) || is_tail_out !== ((i % 4) == 3))
          $display("FAIL burst_send%0d got send=%b data=%h dest=%h tail=%b want 1 %h %h %b",
                   i, send_out, data_out, dest_out, is_tail_out, pat(i), DW'(i + 8'h10), (i % 4) == 3);
        else passes++;
        checks++;
        if (credit_count !== CW'(3 - i) || in_ready !== (i < 3))
          $display("FAIL burst_count%0d got cnt=%0d ready=%b want %0d %b", i, credit_count, in_ready, 3 - i, i < 3);
        else passes++;
      end else begin
        checks++;
        if (send_out !== 1'b0 || data_out !== pat(3) || is_tail_out !== 1'b1 ||
            in_ready !== 1'b0 || credit_count !== '0)
          $display("FAIL burst_stall%0d got send=%b data=%h ready=%b cnt=%0d want 0 %h 0 0",
                   i, send_out, data_out, in_ready, credit_count, pat(3));
        else passes++;
      end
    end
  endtask

  // From zero credits, a single return lets exactly one more flit through.
  task automatic test_credit_return();
    drive_flit(10);
    credit_drv = 1'b1;
    tick();
    credit_drv = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || credit_count !== CW'(1) || send_out !== 1'b0)
      $display("FAIL credit_ready got ready=%b cnt=%0d send=%b want 1 1 0", in_ready, credit_count, send_out);
    else passes++;
    tick();
    checks++;
    if (send_out !== 1'b1 || data_out !== pat(10) || credit_count !== '0 || in_ready !== 1'b0)
      $display("FAIL credit_send got send=%b data=%h cnt=%0d ready=%b want 1 %h 0 0",
               send_out, data_out, credit_count, in_ready, pat(10));
    else passes++;
    tick();
    checks++;
    if (send_out !== 1'b0 || credit_count !== '0)
      $display("FAIL credit_after got send=%b cnt=%0d want 0 0", send_out, credit_count);
    else passes++;
  endtask

  // count = 1 with simultaneous fire and credit: no bubble.
  task automatic test_back_to_back();
    in_valid   = 1'b0;
    in_data    = 'x;
    in_dest    = 'x;
    in_user    = 'x;
    in_is_tail = 1'bx;
    credit_drv = 1'b1;
    tick();
    checks++;
    if (credit_count !== CW'(1) || send_out !== 1'b0 || data_out !== pat(10))
      $display("FAIL b2b_setup got cnt=%0d send=%b data=%h want 1 0 %h", credit_count, send_out, data_out, pat(10));
    else passes++;
    in_valid = 1'b1;
    for (int i = 20; i < 22; i++) begin
      drive_flit(i);
      tick();
      checks++;
      if (send_out !== 1'b1 || data_out !== pat(i) || credit_count !== CW'(1) || in_ready !== 1'b1)
        $display("FAIL b2b_%0d got send=%b data=%h cnt=%0d ready=%b want 1 %h 1 1",
                 i, send_out, data_out, credit_count, in_ready, pat(i));
      else passes++;
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    credit_drv = 1'b0;
    tick();
    checks++;
    if (credit_count !== CW'(NC) || idle !== 1'b1 || credit_overflow !== 1'b0)
      $display("FAIL b2b_refill got cnt=%0d idle=%b ovf=%b want %0d 1 0", credit_count, idle, credit_overflow, NC);
    else passes++;
  endtask

  // Loopback with randomized valid: output order equals acceptance order.
  task automatic test_loopback();
    logic [FW+DW+UW:0] exp_q[$];
    logic [FW+DW+UW:0] cur;
    logic [FW+DW+UW:0] got;
    int sent = 0;
    int recv = 0;
    int errs = 0;
    int budget = 0;
    loop_en = 1'b1;
    while ((sent < 30 || exp_q.size() != 0) && budget < 2000) begin
      if (sent < 30 && ($urandom_range(3) != 0)) begin
        in_valid   = 1'b1;
        in_data    = {$urandom, $urandom, $urandom, $urandom};
        in_dest    = DW'($urandom);
        in_user    = $urandom;
        in_is_tail = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_data, in_dest, in_user, in_is_tail});
        sent++;
      end
      tick();
      budget++;
      if (send_out) begin
        got = {data_out, dest_out, user_out, is_tail_out};
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL loop_extra got %h want no send", got);
        end else begin
          cur = exp_q.pop_front();
          if (got !== cur) begin
            errs++;
            $display("FAIL loop_flit%0d got %h want %h", recv, got, cur);
          end
        end
        recv++;
      end
    end
    in_valid = 1'b0;
    budget = 0;
    while (!idle && budget < 20) begin
      tick();
      budget++;
    end
    tick();
    tick();
    tick();
    checks++;
    if (errs != 0 || recv != 30 || sent != 30)
      $display("FAIL loop_order got errs=%0d recv=%0d sent=%0d want 0 30 30", errs, recv, sent);
    else passes++;
    checks++;
    if (idle !== 1'b1 || credit_count !== CW'(NC) || credit_overflow !== 1'b0)
      $display("FAIL loop_drain got idle=%b cnt=%0d ovf=%b want 1 %0d 0", idle, credit_count, credit_overflow, NC);
    else passes++;
    loop_en = 1'b0;
  endtask

  // Extra credit at full count saturates and sets the sticky flag.
  task automatic test_overflow();
    credit_drv = 1'b1;
    tick();
    credit_drv = 1'b0;
    checks++;
    if (credit_count !== CW'(NC) || credit_overflow !== 1'b1)
      $display("FAIL ovf_set got cnt=%0d ovf=%b want %0d 1", credit_count, credit_overflow, NC);
    else passes++;
    tick();
    tick();
    checks++;
    if (credit_overflow !== 1'b1 || credit_count !== CW'(NC))
      $display("FAIL ovf_sticky got ovf=%b cnt=%0d want 1 %0d", credit_overflow, credit_count, NC);
    else passes++;
  endtask

  // Asynchronous reset mid-burst, then normal sending resumes.
  task automatic test_reset_mid_burst();
    in_valid = 1'b1;
    drive_flit(40);
    tick();
    drive_flit(41);
    tick();
    checks++;
    if (credit_count !== CW'(2) || send_out !== 1'b1 || data_out !== pat(41))
      $display("FAIL mid_pre got cnt=%0d send=%b data=%h want 2 1 %h", credit_count, send_out, data_out, pat(41));
    else passes++;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (send_out !== 1'b0 || credit_count !== CW'(NC) || credit_overflow !== 1'b0 || data_out !== '0)
      $display("FAIL mid_async got send=%b cnt=%0d ovf=%b data=%h want 0 %0d 0 0",
               send_out, credit_count, credit_overflow, data_out, NC);
    else passes++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    drive_flit(50);
    tick();
    in_valid = 1'b0;
    checks++;
    if (send_out !== 1'b1 || data_out !== pat(50) || credit_count !== CW'(NC - 1))
      $display("FAIL mid_resume got send=%b data=%h cnt=%0d want 1 %h %0d",
               send_out, data_out, credit_count, pat(50), NC - 1);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_credit_return();
    test_back_to_back();
    test_loopback();
    test_overflow();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
